// File: rtl/vec_issue_if.sv
// vec_issue_if: handshake bundle between the scalar pipeline, vec_issue_unit and the vector coprocessor
//   sc_*  : scalar-side request (valid/ready + instr/rs1/rs2), flush, and response (valid/ready + data/illegal/timeout)
//   vec_* : coprocessor-side issue (valid + instruction/rs1/rs2) and completion (ack + is_vec/csr_out)
//   slave  = view of vec_issue_unit, master = view of the surrounding core/coprocessor
interface vec_issue_if #(parameter int XLEN = 32);
  logic            sc_valid, sc_ready, sc_flush;
  logic [XLEN-1:0] sc_instr, sc_rs1, sc_rs2;
  logic            sc_resp_valid, sc_resp_ready, sc_resp_illegal, sc_resp_timeout;
  logic [XLEN-1:0] sc_resp_data;
  logic            vec_valid, vec_ack, vec_is_vec;
  logic [XLEN-1:0] vec_instruction, vec_rs1_data, vec_rs2_data, vec_csr_out;
  modport slave (
    input  sc_valid, sc_instr, sc_rs1, sc_rs2, sc_flush, sc_resp_ready, vec_ack, vec_is_vec, vec_csr_out,
    output sc_ready, sc_resp_valid, sc_resp_data, sc_resp_illegal, sc_resp_timeout,
           vec_valid, vec_instruction, vec_rs1_data, vec_rs2_data
  );
  modport master (
    output sc_valid, sc_instr, sc_rs1, sc_rs2, sc_flush, sc_resp_ready, vec_ack, vec_is_vec, vec_csr_out,
    input  sc_ready, sc_resp_valid, sc_resp_data, sc_resp_illegal, sc_resp_timeout,
           vec_valid, vec_instruction, vec_rs1_data, vec_rs2_data
  );
endinterface

// File: rtl/vec_issue_unit.sv
// vec_issue_unit: FIFO-buffered dispatcher of vector instructions from the scalar core to the vector coprocessor
//   clk_i   : rising-edge clock
//   reset_i : asynchronous active-high reset
//   io      : vec_issue_if.slave (scalar request/flush/response, vector issue/ack)
module vec_issue_unit #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  vec_issue_if.slave  io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            ill_q, ill_d, to_q, to_d;
  logic [3*XLEN-1:0] mem [DEPTH];
  logic [3*XLEN-1:0] head;
  logic            push, pop, issuing;
  assign issuing          = state_q == ISSUE;
  assign io.sc_ready      = count_q != CW'(DEPTH);
  assign push             = io.sc_valid && io.sc_ready && !io.sc_flush;
  assign pop              = state_q == RESP && io.sc_resp_ready;
  assign head             = issuing ? mem[rd_ptr_q] : '0;
  assign io.vec_valid     = issuing;
  assign io.vec_instruction = head[3*XLEN-1:2*XLEN];
  assign io.vec_rs1_data  = head[2*XLEN-1:XLEN];
  assign io.vec_rs2_data  = head[XLEN-1:0];
  assign io.sc_resp_valid   = state_q == RESP;
  assign io.sc_resp_data    = data_q;
  assign io.sc_resp_illegal = ill_q;
  assign io.sc_resp_timeout = to_q;
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr_q] <= {io.sc_instr, io.sc_rs1, io.sc_rs2};
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    data_d   = data_q;
    ill_d    = ill_q;
    to_d     = to_q;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    // Flush: idle drops everything; otherwise only the in-flight head survives (and may pop this edge)
    if (io.sc_flush) begin
      rd_ptr_d = state_q == IDLE ? wr_ptr_q : rd_ptr_d;
      wr_ptr_d = state_q == IDLE ? wr_ptr_q : rd_ptr_q + AW'(1);
      count_d  = (state_q == IDLE || pop) ? '0 : CW'(1);
    end
    case (state_q)
      IDLE: if (count_q != '0 && !io.sc_flush) begin
        state_d = ISSUE;
        timer_d = '0;
      end
      ISSUE: begin
        timer_d = timer_q + TW'(1);
        // Ack wins over a timeout expiring on the same cycle
        if (io.vec_ack || timer_q == TW'(TIMEOUT - 1)) begin
          state_d = RESP;
          ill_d   = !io.vec_ack || !io.vec_is_vec;
          to_d    = !io.vec_ack;
          data_d  = (io.vec_ack && io.vec_is_vec) ? io.vec_csr_out : '0;
        end
      end
      RESP: if (io.sc_resp_ready) begin
        state_d = IDLE;
        timer_d = '0;
        data_d  = '0;
        ill_d   = 1'b0;
        to_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
    end
endmodule

// File: tb/tb_vec_issue_unit.sv
// tb_vec_issue_unit: directed stimulus with a queue-level reference model checked every cycle
module tb_vec_issue_unit;
  localparam int XLEN = 32, DEPTH = 4, TIMEOUT = 16;
  typedef struct packed { logic [XLEN-1:0] instr, rs1, rs2; } ent_t;
  logic clk = 0, rst = 1;
  int vectors = 0, miscompares = 0;
  int vv_cycles = 0, issues = 0;
  bit vv_prev = 0, ack_en = 0, ack_isvec = 1;
  logic [XLEN+1:0] rlog[$];
  ent_t q[$];
  int phase = 0, wt = 0;
  logic [XLEN-1:0] m_data = '0;
  logic m_ill = 0, m_to = 0;
  always #5 clk = ~clk;
  vec_issue_if #(.XLEN(XLEN)) bus();
  vec_issue_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk_i(clk), .reset_i(rst), .io(bus));
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: queue of pending entries, phase 0=idle 1=issuing head 2=response pending
  always @(posedge clk or posedge rst) begin : model
    bit push;
    if (rst) begin
      q.delete(); phase = 0; wt = 0; m_data = '0; m_ill = 0; m_to = 0;
    end else begin
      push = bus.sc_valid && q.size() != DEPTH && !bus.sc_flush;
      if (bus.sc_flush) begin
        if (phase == 0) q.delete();
        else while (q.size() > 1) void'(q.pop_back());
      end
      if (phase == 0) begin
        if (q.size() > 0 && !bus.sc_flush) begin phase = 1; wt = 0; end
      end else if (phase == 1) begin
        if (bus.vec_ack) begin
          phase = 2; m_to = 0; m_ill = !bus.vec_is_vec; m_data = bus.vec_is_vec ? bus.vec_csr_out : '0;
        end else if (wt == TIMEOUT - 1) begin
          phase = 2; m_to = 1; m_ill = 1; m_data = '0;
        end else wt++;
      end else if (bus.sc_resp_ready) begin
        void'(q.pop_front()); phase = 0; m_data = '0; m_ill = 0; m_to = 0;
      end
      if (push) q.push_back(ent_t'{bus.sc_instr, bus.sc_rs1, bus.sc_rs2});
    end
  end
  always @(negedge clk) begin : compare
    ent_t h;
    if (!rst) begin
      h = (phase == 1) ? q[0] : '0;
      check("sc_ready", 128'(bus.sc_ready), 128'(q.size() != DEPTH));
      check("vec_bus", 128'({bus.vec_valid, bus.vec_instruction, bus.vec_rs1_data, bus.vec_rs2_data}), 128'({phase == 1, h}));
      check("resp", 128'({bus.sc_resp_valid, bus.sc_resp_timeout, bus.sc_resp_illegal, bus.sc_resp_data}), 128'({phase == 2, m_to, m_ill, m_data}));
    end
  end
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.vec_valid) vv_cycles++;
      if (bus.vec_valid && !vv_prev) issues++;
      if (bus.sc_resp_valid && bus.sc_resp_ready) rlog.push_back({bus.sc_resp_timeout, bus.sc_resp_illegal, bus.sc_resp_data});
    end
    vv_prev = bus.vec_valid;
  end
  // Coprocessor stand-in: acks in the first issue cycle and returns rs1 as the CSR result
  always @(negedge clk) begin
    #1;
    bus.vec_ack     = ack_en && bus.vec_valid;
    bus.vec_is_vec  = ack_en && bus.vec_valid && ack_isvec;
    bus.vec_csr_out = (ack_en && bus.vec_valid) ? bus.vec_rs1_data : '0;
  end
  task automatic cyc();
    @(negedge clk); #1;
  endtask
  task automatic drain(input int n);
    repeat (n) cyc();
  endtask
  task automatic push(input logic [XLEN-1:0] i, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    bit acc;
    acc = 0;
    bus.sc_valid = 1; bus.sc_instr = i; bus.sc_rs1 = r1; bus.sc_rs2 = r2;
    for (int n = 0; n < 100; n++) begin
      acc = bus.sc_ready;
      cyc();
      if (acc) break;
    end
    check("push_accept", 128'(acc), 128'(1));
    bus.sc_valid = 0;
  endtask
  task automatic wait_log(input int n);
    for (int k = 0; k < 200 && rlog.size() < n; k++) cyc();
    check("resp_count", 128'(rlog.size()), 128'(n));
  endtask
  initial begin : main
    int base, v0, i0;
    bus.sc_valid = 0; bus.sc_instr = '0; bus.sc_rs1 = '0; bus.sc_rs2 = '0;
    bus.sc_flush = 0; bus.sc_resp_ready = 1;
    #1;
    check("rst_ready", 128'(bus.sc_ready), 128'(1));
    check("rst_vvalid", 128'(bus.vec_valid), 128'(0));
    check("rst_rvalid", 128'(bus.sc_resp_valid), 128'(0));
    cyc(); cyc();
    rst = 0;
    // Single legal op with exact latency
    ack_en = 1; ack_isvec = 1; v0 = vv_cycles;
    push(32'h0C0572D7, 32'd8, 32'd0);
    check("lat_e0", 128'(bus.vec_valid), 128'(0));
    cyc();
    check("lat_e1", 128'(bus.vec_valid), 128'(1));
    cyc();
    check("lat_e2", 128'(bus.sc_resp_valid), 128'(1));
    drain(3);
    check("legal_vv_cycles", 128'(vv_cycles - v0), 128'(1));
    wait_log(1);
    check("legal_resp", 128'(rlog[0]), 128'({2'b00, 32'd8}));
    // Illegal op
    ack_isvec = 0;
    push(32'h00000013, 32'h55, 32'd0);
    wait_log(2);
    check("illegal_resp", 128'(rlog[1]), 128'({2'b01, 32'd0}));
    // Fill with response backpressure
    ack_isvec = 1; bus.sc_resp_ready = 0; base = rlog.size();
    for (int i = 0; i < 4; i++) push(32'h1000 + i, 32'h101 + i, i);
    check("full_after_4", 128'(bus.sc_ready), 128'(0));
    fork
      push(32'h1004, 32'h105, 32'd4);
      begin
        drain(3);
        check("still_full", 128'(bus.sc_ready), 128'(0));
        bus.sc_resp_ready = 1;
      end
    join
    wait_log(base + 5);
    for (int i = 0; i < 5; i++) check("fill_order", 128'(rlog[base + i]), 128'({2'b00, 32'h101 + i}));
    // Timeout
    ack_en = 0; v0 = vv_cycles;
    push(32'hDEAD, 32'h77, 32'd0);
    wait_log(base + 6);
    drain(2);
    check("timeout_vv_cycles", 128'(vv_cycles - v0), 128'(16));
    check("timeout_resp", 128'(rlog[base + 5]), 128'({2'b11, 32'd0}));
    // Flush while head is issuing
    i0 = issues;
    push(32'h2001, 32'h201, 32'd0);
    push(32'h2002, 32'h202, 32'd0);
    push(32'h2003, 32'h203, 32'd0);
    bus.sc_flush = 1;
    cyc();
    bus.sc_flush = 0; ack_en = 1;
    wait_log(base + 7);
    drain(6);
    check("flush_issues", 128'(issues - i0), 128'(1));
    check("flush_resp", 128'(rlog[base + 6]), 128'({2'b00, 32'h201}));
    check("flush_empty", 128'(bus.sc_ready), 128'(1));
    check("flush_resp_total", 128'(rlog.size()), 128'(base + 7));
    // Asynchronous reset mid-issue
    ack_en = 0;
    push(32'hBEEF, 32'h99, 32'd0);
    cyc();
    check("pre_rst_vvalid", 128'(bus.vec_valid), 128'(1));
    #2 rst = 1;
    #1;
    check("arst_vvalid", 128'(bus.vec_valid), 128'(0));
    check("arst_vinstr", 128'(bus.vec_instruction), 128'(0));
    check("arst_ready", 128'(bus.sc_ready), 128'(1));
    check("arst_rvalid", 128'(bus.sc_resp_valid), 128'(0));
    v0 = rlog.size();
    cyc();
    rst = 0;
    drain(20);
    check("arst_no_resp", 128'(rlog.size()), 128'(v0));
    check("arst_idle", 128'(bus.vec_valid), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
